// File: rtl/conv_layer_pkg.sv
// Shared FSM state type, load timing constant and signed max helper for the
// conv/pool layer sequencer.
package conv_layer_pkg;

  typedef enum logic [2:0] {
    S_IDLE,
    S_LOAD,
    S_FETCH,
    S_ISSUE,
    S_DRAIN,
    S_DONE
  } state_t;

  localparam int LOAD_CYCLES = 2;
  localparam int MAX_W       = 64;

  // Callers sign-extend narrower words to MAX_W and take the low bits back.
  function automatic logic signed [MAX_W-1:0] smax(input logic signed [MAX_W-1:0] a,
                                                    input logic signed [MAX_W-1:0] b);
    return (a > b) ? a : b;
  endfunction

endpackage

// File: rtl/conv_pool_layer_ctrl_pool.sv
// Streaming group-of-POOL_N signed max reducer; out_vld pulses one cycle after
// the last member of each group arrives.
module pool_max_acc
  import conv_layer_pkg::*;
#(
  parameter int WIDTH  = 16,
  parameter int POOL_N = 4
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             clr,
  input  logic             in_vld,
  input  logic [WIDTH-1:0] in_data,
  output logic             out_vld,
  output logic [WIDTH-1:0] out_data
);

  localparam int CW = (POOL_N > 1) ? $clog2(POOL_N) : 1;

  logic [CW-1:0]           cnt_q;
  logic signed [WIDTH-1:0] acc_q;
  logic signed [WIDTH-1:0] in_s;
  logic signed [WIDTH-1:0] mx;
  logic signed [MAX_W-1:0] max_w;

  assign in_s  = in_data;
  assign max_w = smax(MAX_W'(acc_q), MAX_W'(in_s));
  // The first member of a group seeds the accumulator regardless of its old value.
  assign mx    = (cnt_q == '0) ? in_s : max_w[WIDTH-1:0];

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      cnt_q    <= '0;
      acc_q    <= '0;
      out_vld  <= 1'b0;
      out_data <= '0;
    end else begin
      out_vld <= 1'b0;
      if (clr) begin
        cnt_q <= '0;
      end else if (in_vld) begin
        if (cnt_q == CW'(POOL_N - 1)) begin
          cnt_q    <= '0;
          out_vld  <= 1'b1;
          out_data <= mx;
        end else begin
          cnt_q <= cnt_q + 1'b1;
          acc_q <= mx;
        end
      end
    end
  end

endmodule

// File: rtl/conv_pool_layer_ctrl.sv
// Layer sequencer: per kernel, fetch K-row windows, issue them to the calc unit,
// max-pool the results and write them to kernel-banked addresses.
// Define RELU_EN to clamp negative pooled values to zero before the write.
module conv_pool_layer_ctrl
  import conv_layer_pkg::*;
#(
  parameter int WIDTH       = 16,
  parameter int K           = 5,
  parameter int NUM_KERNELS = 6,
  parameter int WINDOWS     = 576,
  parameter int CALC_LAT    = 7,
  parameter int POOL_N      = 4,
  parameter int OUT_STRIDE  = 1024,
  parameter int ADDR_W      = 32
) (
  input  logic                           clk,
  input  logic                           rst_n,
  input  logic                           layer_en_i,
  output logic                           busy_o,
  output logic                           done_o,
  output logic [ADDR_W-1:0]              ker_idx_o,
  input  logic [K*K*WIDTH-1:0]           ker_data_i,
  input  logic [WIDTH-1:0]               bias_i,
  output logic                           rd_en_o,
  output logic [ADDR_W-1:0]              rd_win_o,
  output logic [ADDR_W-1:0]              rd_row_o,
  input  logic [K*WIDTH-1:0]             rd_data_i,
  output logic                           calc_valid_o,
  output logic [(2*K*K+1)*WIDTH-1:0]     calc_data_o,
  input  logic [WIDTH-1:0]               calc_result_i,
  output logic                           wr_en_o,
  output logic [ADDR_W-1:0]              wr_addr_o,
  output logic [WIDTH-1:0]               wr_data_o
);

  localparam int RW = K * WIDTH;
  localparam int KW = K * K * WIDTH;

  state_t              state_q, state_d;
  logic [ADDR_W-1:0]   ker_idx_q, win_cnt_q, row_cnt_q, out_cnt_q, load_cnt_q;
  logic [KW-1:0]       ker_q, win_q, win_next;
  logic [WIDTH-1:0]    bias_q;
  logic                rd_vld_p1;
  logic [ADDR_W-1:0]   row_p1;
  logic [CALC_LAT-1:0] vld_pipe;
  logic                load_entry;
  logic                pool_vld;
  logic [WIDTH-1:0]    pool_data;

  function automatic logic signed [WIDTH-1:0] relu(input logic signed [WIDTH-1:0] v);
`ifdef RELU_EN
    return v[WIDTH-1] ? '0 : v;
`else
    return v;
`endif
  endfunction

  always_comb begin
    state_d      = state_q;
    busy_o       = 1'b0;
    done_o       = 1'b0;
    rd_en_o      = 1'b0;
    calc_valid_o = 1'b0;
    case (state_q)
      S_IDLE:  if (layer_en_i) state_d = S_LOAD;
      S_LOAD: begin
        busy_o = 1'b1;
        if (load_cnt_q == ADDR_W'(LOAD_CYCLES - 1)) state_d = S_FETCH;
      end
      S_FETCH: begin
        busy_o  = 1'b1;
        rd_en_o = 1'b1;
        if (row_cnt_q == ADDR_W'(K - 1)) state_d = S_ISSUE;
      end
      S_ISSUE: begin
        busy_o       = 1'b1;
        calc_valid_o = 1'b1;
        state_d      = (win_cnt_q < ADDR_W'(WINDOWS - 1)) ? S_FETCH : S_DRAIN;
      end
      // The final pooled write is registered and leaves on the same cycle the
      // valid pipe runs empty, so exiting here never drops it.
      S_DRAIN: begin
        busy_o = 1'b1;
        if (vld_pipe == '0)
          state_d = (ker_idx_q < ADDR_W'(NUM_KERNELS - 1)) ? S_LOAD : S_DONE;
      end
      S_DONE: begin
        done_o  = 1'b1;
        state_d = S_IDLE;
      end
      default: state_d = S_IDLE;
    endcase
  end

  assign load_entry = (state_d == S_LOAD) && (state_q != S_LOAD);

  // The last row lands on the ISSUE cycle; merge it combinationally so the
  // issued window is complete.
  always_comb begin
    win_next = win_q;
    if (rd_vld_p1) win_next[(K - 1 - int'(row_p1)) * RW +: RW] = rd_data_i;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q    <= S_IDLE;
      ker_idx_q  <= '0;
      win_cnt_q  <= '0;
      row_cnt_q  <= '0;
      out_cnt_q  <= '0;
      load_cnt_q <= '0;
      ker_q      <= '0;
      bias_q     <= '0;
      win_q      <= '0;
      rd_vld_p1  <= 1'b0;
      row_p1     <= '0;
      vld_pipe   <= '0;
    end else begin
      state_q   <= state_d;
      // fetch -> window register stage
      rd_vld_p1 <= rd_en_o;
      row_p1    <= row_cnt_q;
      win_q     <= win_next;
      // issue -> result stage (CALC_LAT deep)
      vld_pipe  <= (vld_pipe << 1) | CALC_LAT'(calc_valid_o);
      case (state_q)
        S_IDLE:  if (layer_en_i) ker_idx_q <= '0;
        S_LOAD: begin
          load_cnt_q <= load_cnt_q + 1'b1;
          ker_q      <= ker_data_i;
          bias_q     <= bias_i;
          win_cnt_q  <= '0;
          row_cnt_q  <= '0;
        end
        S_FETCH: row_cnt_q <= (row_cnt_q == ADDR_W'(K - 1)) ? '0 : row_cnt_q + 1'b1;
        S_ISSUE: win_cnt_q <= win_cnt_q + 1'b1;
        S_DRAIN: if (state_d == S_LOAD) ker_idx_q <= ker_idx_q + 1'b1;
        default: ;
      endcase
      if (load_entry) begin
        load_cnt_q <= '0;
        out_cnt_q  <= '0;
      end else if (pool_vld) begin
        out_cnt_q <= out_cnt_q + 1'b1;
      end
    end
  end

  pool_max_acc #(
    .WIDTH  (WIDTH),
    .POOL_N (POOL_N)
  ) u_pool (
    .clk      (clk),
    .rst_n    (rst_n),
    .clr      (load_entry),
    .in_vld   (vld_pipe[CALC_LAT-1]),
    .in_data  (calc_result_i),
    .out_vld  (pool_vld),
    .out_data (pool_data)
  );

  assign ker_idx_o   = ker_idx_q;
  assign rd_win_o    = win_cnt_q;
  assign rd_row_o    = row_cnt_q;
  assign calc_data_o = {ker_q, win_next, bias_q};
  assign wr_en_o     = pool_vld;
  assign wr_addr_o   = ker_idx_q * ADDR_W'(OUT_STRIDE) + out_cnt_q;
  assign wr_data_o   = relu(pool_data);

endmodule

// File: tb/tb_conv_pool_layer_ctrl.sv
// Scoreboard bench for conv_pool_layer_ctrl: ROM, feature buffer and calc unit
// models drive the DUT; expected writes are queued at issue time.
module tb_conv_pool_layer_ctrl;

  localparam int W    = 16;
  localparam int KK   = 3;
  localparam int NK   = 2;
  localparam int NWIN = 8;
  localparam int CL   = 3;
  localparam int PN   = 4;
  localparam int OS   = 16;
  localparam int AW   = 32;
  localparam int CDW  = (2*KK*KK+1)*W;
  localparam int GPK  = NWIN / PN;

  typedef logic [CDW-1:0] wide_t;

  logic                 clk = 1'b0;
  logic                 rst_n;
  logic                 layer_en_i;
  logic                 busy_o, done_o, rd_en_o, calc_valid_o, wr_en_o;
  logic [AW-1:0]        ker_idx_o, rd_win_o, rd_row_o, wr_addr_o;
  logic [KK*KK*W-1:0]   ker_data_i;
  logic [W-1:0]         bias_i, calc_result_i, wr_data_o;
  logic [KK*W-1:0]      rd_data_i;
  logic [CDW-1:0]       calc_data_o;

  always #5 clk = ~clk;

  conv_pool_layer_ctrl #(
    .WIDTH(W), .K(KK), .NUM_KERNELS(NK), .WINDOWS(NWIN), .CALC_LAT(CL),
    .POOL_N(PN), .OUT_STRIDE(OS), .ADDR_W(AW)
  ) dut (
    .clk(clk), .rst_n(rst_n), .layer_en_i(layer_en_i), .busy_o(busy_o), .done_o(done_o),
    .ker_idx_o(ker_idx_o), .ker_data_i(ker_data_i), .bias_i(bias_i),
    .rd_en_o(rd_en_o), .rd_win_o(rd_win_o), .rd_row_o(rd_row_o), .rd_data_i(rd_data_i),
    .calc_valid_o(calc_valid_o), .calc_data_o(calc_data_o), .calc_result_i(calc_result_i),
    .wr_en_o(wr_en_o), .wr_addr_o(wr_addr_o), .wr_data_o(wr_data_o)
  );

  int n_chk = 0;
  int n_err = 0;

  task automatic chk(input string tag, input wide_t act, input wide_t exp);
    n_chk++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h expected %0h", tag, act, exp);
    end
  endtask

  logic signed [W-1:0] res_tab [16] = '{
    16'sd5,    -16'sd2,     16'sd9,   16'sd1,
    -16'sd7,   -16'sd3,    -16'sd9,  -16'sd4,
    16'sd100,  -16'sd300,  -16'sd50,  16'sd250,
    16'sh8000, -16'sd32767, -16'sd1, -16'sd20000
  };

  function automatic logic [KK*W-1:0] row_word(input int w, input int r);
    logic [KK*W-1:0] v = '0;
    for (int c = 0; c < KK; c++) v = {v[(KK-1)*W-1:0], 16'(16'h0101 * (r*KK + c + 1) + w * 16'h1000)};
    return v;
  endfunction

  function automatic logic [KK*KK*W-1:0] ker_word(input int k);
    logic [KK*KK*W-1:0] v = '0;
    for (int j = 0; j < KK*KK; j++) v = {v[(KK*KK-1)*W-1:0], 16'(16'hA000 + k * 16'h0100 + j)};
    return v;
  endfunction

  function automatic logic [W-1:0] bias_word(input int k);
    return 16'(16'hB000 + k);
  endfunction

  function automatic wide_t exp_calc(input int k, input int w);
    return {ker_word(k), row_word(w, 0), row_word(w, 1), row_word(w, 2), bias_word(k)};
  endfunction

  function automatic logic [W-1:0] pool_exp(input int g);
    logic signed [W-1:0] m = res_tab[g*PN];
    for (int i = 1; i < PN; i++) if (res_tab[g*PN + i] > m) m = res_tab[g*PN + i];
`ifdef RELU_EN
    if (m < 0) m = '0;
`endif
    return m;
  endfunction

  logic [W-1:0]    dly [0:CL];
  logic [KK*W-1:0] rd_pend = '0;
  int              k_last = 0;
  int              iss_cnt = 0, wr_cnt = 0, done_cnt = 0, cyc = 0, last_iss = 0;
  int              kk, ww, gg;
  logic [AW-1:0]   exp_addr [$];
  logic [W-1:0]    exp_data [$];

  always @(negedge clk) begin
    // drive the calc, buffer and ROM models
    for (int i = CL; i > 0; i--) dly[i] = dly[i-1];
    dly[0]        = calc_valid_o ? res_tab[iss_cnt % 16] : 16'h7FFF;
    calc_result_i = dly[CL];
    rd_data_i     = rd_pend;
    rd_pend       = rd_en_o ? row_word(int'(rd_win_o), int'(rd_row_o)) : 48'hDEADDEADDEAD;
    ker_data_i    = ker_word(k_last);
    bias_i        = bias_word(k_last);
    k_last        = int'(ker_idx_o);
    #1;
    if (calc_valid_o) begin
      kk = iss_cnt / NWIN;
      ww = iss_cnt % NWIN;
      chk("issue_ker", wide_t'(ker_idx_o), wide_t'(kk));
      chk("issue_data", calc_data_o, exp_calc(kk, ww));
      if (ww != 0) chk("issue_gap", wide_t'(cyc - last_iss), wide_t'(KK + 1));
      last_iss = cyc;
      if (ww % PN == PN - 1) begin
        gg = iss_cnt / PN;
        exp_addr.push_back(AW'((gg / GPK) * OS + gg % GPK));
        exp_data.push_back(pool_exp(gg));
      end
      iss_cnt++;
    end
    if (wr_en_o) begin
      wr_cnt++;
      if (exp_addr.size() == 0) begin
        chk("wr_unexpected", wide_t'(1), wide_t'(0));
      end else begin
        chk("wr_addr", wide_t'(wr_addr_o), wide_t'(exp_addr.pop_front()));
        chk("wr_data", wide_t'(wr_data_o), wide_t'(exp_data.pop_front()));
      end
    end
    if (done_o) begin
      done_cnt++;
      chk("done_busy", wide_t'(busy_o), wide_t'(0));
    end
    cyc++;
  end

  task automatic check_idle_outputs(input string tag);
    chk({tag, "_busy"},  wide_t'(busy_o),       wide_t'(0));
    chk({tag, "_done"},  wide_t'(done_o),       wide_t'(0));
    chk({tag, "_rden"},  wide_t'(rd_en_o),      wide_t'(0));
    chk({tag, "_cval"},  wide_t'(calc_valid_o), wide_t'(0));
    chk({tag, "_wren"},  wide_t'(wr_en_o),      wide_t'(0));
    chk({tag, "_kidx"},  wide_t'(ker_idx_o),    wide_t'(0));
    chk({tag, "_rdrow"}, wide_t'(rd_row_o),     wide_t'(0));
    chk({tag, "_rdwin"}, wide_t'(rd_win_o),     wide_t'(0));
    chk({tag, "_waddr"}, wide_t'(wr_addr_o),    wide_t'(0));
    chk({tag, "_wdata"}, wide_t'(wr_data_o),    wide_t'(0));
    chk({tag, "_cdata"}, calc_data_o,           wide_t'(0));
  endtask

  task automatic pulse_start();
    layer_en_i = 1'b1;
    @(negedge clk);
    layer_en_i = 1'b0;
  endtask

  task automatic wait_done(input int d0);
    int c = 0;
    while (done_cnt == d0 && c < 1000) begin
      @(negedge clk);
      c++;
    end
    chk("done_timeout", wide_t'(done_cnt != d0), wide_t'(1));
  endtask

  task automatic wait_issues(input int n);
    int c = 0;
    while (iss_cnt < n && c < 500) begin
      @(negedge clk);
      c++;
    end
    chk("issue_timeout", wide_t'(iss_cnt >= n), wide_t'(1));
  endtask

  task automatic run_checks(input int d0, input int w0);
    chk("run_issues", wide_t'(iss_cnt),         wide_t'(NK * NWIN));
    chk("run_writes", wide_t'(wr_cnt),          wide_t'(w0 + NK * GPK));
    chk("run_queue",  wide_t'(exp_addr.size()), wide_t'(0));
    chk("run_dones",  wide_t'(done_cnt),        wide_t'(d0 + 1));
    chk("run_busy",   wide_t'(busy_o),          wide_t'(0));
  endtask

  int d0, w0;

  initial begin
    rst_n      = 1'b0;
    layer_en_i = 1'b0;
    for (int i = 0; i <= CL; i++) dly[i] = 16'h7FFF;
    repeat (3) @(negedge clk);
    check_idle_outputs("rst");
    rst_n = 1'b1;
    @(negedge clk);

    // full run, with a stray start pulse during the kernel-0 drain
    d0 = done_cnt; w0 = wr_cnt; iss_cnt = 0;
    pulse_start();
    chk("start_busy", wide_t'(busy_o), wide_t'(1));
    wait_issues(NWIN);
    repeat (2) @(negedge clk);
    pulse_start();
    wait_done(d0);
    repeat (20) @(negedge clk);
    run_checks(d0, w0);

    // reset during the second window's fetch
    d0 = done_cnt; iss_cnt = 0;
    pulse_start();
    wait_issues(1);
    @(negedge clk);
    #2 rst_n = 1'b0;
    #1 check_idle_outputs("midrst");
    repeat (3) @(negedge clk);
    rst_n = 1'b1;
    w0 = wr_cnt;
    repeat (40) @(negedge clk);
    chk("postrst_writes", wide_t'(wr_cnt),   wide_t'(w0));
    chk("postrst_issues", wide_t'(iss_cnt),  wide_t'(1));
    chk("postrst_dones",  wide_t'(done_cnt), wide_t'(d0));
    exp_addr.delete();
    exp_data.delete();

    // clean run after the abort
    d0 = done_cnt; w0 = wr_cnt; iss_cnt = 0;
    pulse_start();
    wait_done(d0);
    repeat (10) @(negedge clk);
    run_checks(d0, w0);

    $display("Result: errors=%0d of %0d checks", n_err, n_chk);
    $finish;
  end

  initial begin
    #100000;
    $display("FAIL watchdog: simulation did not finish, errors=%0d", n_err);
    $fatal(1);
  end

endmodule
